block_mem_param: RTL and testbench



---
 rtl/mem_pkg.sv | 17 +
 rtl/block_mem_param_if.sv | 20 ++
 rtl/block_mem_array.sv | 30 +++
 rtl/block_mem_param.sv | 90 +++++++++
 tb/tb_block_mem_param.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and elaboration-time helpers for the block data memory.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int words(input int block_w, input int word_w);
    return block_w / word_w;
  endfunction

endpackage

// File: rtl/block_mem_param_if.sv
// Request/response bundle between the L1 controller and the block memory.
interface block_mem_param_if #(
  parameter int ADDR_W  = 16,
  parameter int BLOCK_W = 128,
  parameter int WORD_W  = 32
);
  logic                      ren;
  logic                      wen;
  logic [ADDR_W-1:0]         block_address;
  logic [BLOCK_W-1:0]        din;
  logic [BLOCK_W/WORD_W-1:0] wmask;
  logic                      ready;
  logic                      done;
  logic [BLOCK_W-1:0]        dout;

  modport master (output ren, wen, block_address, din, wmask,
                  input  ready, done, dout);
  modport slave  (input  ren, wen, block_address, din, wmask,
                  output ready, done, dout);
endinterface

// File: rtl/block_mem_array.sv
// Single-port block storage: per-word masked write, registered read.
module block_mem_array import mem_pkg::*; #(
  parameter int BLOCK_W    = 128,
  parameter int WORD_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rd_en,
  input  logic                      wr_en,
  input  logic [DEPTH_LOG2-1:0]     index,
  input  logic [BLOCK_W-1:0]        wdata,
  input  logic [BLOCK_W/WORD_W-1:0] wmask,
  output logic [BLOCK_W-1:0]        rdata
);
  localparam int WORDS = words(BLOCK_W, WORD_W);

  logic [WORDS-1:0][WORD_W-1:0] mem [2**DEPTH_LOG2];

  // Storage has no reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    for (int i = 0; i < WORDS; i++)
      if (wr_en && wmask[i]) mem[index][i] <= wdata[i*WORD_W +: WORD_W];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      rdata <= '0;
    else if (rd_en) rdata <= mem[index];
  end
endmodule

// File: rtl/block_mem_param.sv
// Multi-cycle block memory: latches a request at accept, counts out the latency, then completes.
module block_mem_param import mem_pkg::*; #(
  parameter int ADDR_W     = 16,
  parameter int BLOCK_W    = 128,
  parameter int WORD_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 10,
  parameter int WR_LAT     = 10
) (
  input  logic             clock,
  input  logic             reset,
  block_mem_param_if.slave bus
);
  localparam int WORDS   = words(BLOCK_W, WORD_W);
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  // Keep at least one counter bit when both latencies are 1.
  localparam int CNT_W   = (clog2(MAX_LAT) > 0) ? clog2(MAX_LAT) : 1;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  op_wr;
  logic [DEPTH_LOG2-1:0] idx;
  logic [BLOCK_W-1:0]    din_q;
  logic [WORDS-1:0]      wmask_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  fire;

  assign fire = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      idx     <= '0;
      din_q   <= '0;
      wmask_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.ren || bus.wen) begin
          // Write takes priority when both are requested.
          op_wr   <= bus.wen;
          idx     <= bus.block_address[DEPTH_LOG2-1:0];
          din_q   <= bus.din;
          wmask_q <= bus.wmask;
          cnt     <= bus.wen ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
          ready_q <= 1'b0;
          state   <= BUSY;
        end
        BUSY: if (cnt == '0) begin
          done_q <= 1'b1;
          state  <= DONE;
        end else begin
          cnt <= cnt - 1'b1;
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  block_mem_array #(
    .BLOCK_W    (BLOCK_W),
    .WORD_W     (WORD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .rd_en (fire && !op_wr),
    .wr_en (fire && op_wr),
    .index (idx),
    .wdata (din_q),
    .wmask (wmask_q),
    .rdata (bus.dout)
  );

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_block_mem_param.sv
// Bench for block_mem_param: default-parameter instance plus a narrow, short-latency instance.
module tb_block_mem_param;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  block_mem_param_if #(.ADDR_W(16), .BLOCK_W(128), .WORD_W(32)) b0 ();
  block_mem_param_if #(.ADDR_W(16), .BLOCK_W(64),  .WORD_W(16)) b1 ();

  block_mem_param u0 (.clock(clock), .reset(reset), .bus(b0));
  block_mem_param #(.ADDR_W(16), .BLOCK_W(64), .WORD_W(16), .DEPTH_LOG2(10),
                    .RD_LAT(1), .WR_LAT(3)) u1 (.clock(clock), .reset(reset), .bus(b1));

  typedef struct {
    logic         r;
    logic         w;
    logic [15:0]  a;
    logic [127:0] d;
    logic [3:0]   m;
    logic [127:0] e;
  } vec_t;

  vec_t tv[13];
  logic [127:0] sb0[$];
  logic [63:0]  sb1[$];
  logic [63:0]  m1 [1024];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run0(input logic r, input logic w, input logic [15:0] a,
                      input logic [127:0] d, input logic [3:0] m,
                      input logic [127:0] e, input int lat);
    int n;
    n = 0;
    @(negedge clock);
    while (!b0.ready && n < 30) begin @(negedge clock); n++; end
    if (!b0.ready) chk("ready_wait0", 0, 1);
    b0.ren = r; b0.wen = w; b0.block_address = a; b0.din = d; b0.wmask = m;
    sb0.push_back(e);
    @(posedge clock);
    #1 b0.ren = 1'b0; b0.wen = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!b0.done && n < 40);
    chk("latency0", 128'(n - 1), 128'(lat));
    chk("dout0", b0.dout, sb0.pop_front());
    @(negedge clock);
    chk("done_drop0", 128'(b0.done), 0);
    chk("ready_back0", 128'(b0.ready), 1);
  endtask

  task automatic run1(input logic r, input logic w, input logic [15:0] a,
                      input logic [63:0] d, input logic [3:0] m,
                      input logic [63:0] e, input int lat);
    int n;
    n = 0;
    @(negedge clock);
    while (!b1.ready && n < 30) begin @(negedge clock); n++; end
    if (!b1.ready) chk("ready_wait1", 0, 1);
    b1.ren = r; b1.wen = w; b1.block_address = a; b1.din = d; b1.wmask = m;
    sb1.push_back(e);
    @(posedge clock);
    #1 b1.ren = 1'b0; b1.wen = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!b1.done && n < 40);
    chk("latency1", 128'(n - 1), 128'(lat));
    chk("dout1", 128'(b1.dout), 128'(sb1.pop_front()));
  endtask

  initial begin
    logic [127:0] aa, ff, pat, z, wv, x7, y7, pre;
    logic [63:0]  last1, d1;
    logic [3:0]   mk;
    logic [15:0]  a1;
    int dones, when;

    aa  = {4{32'hAAAAAAAA}};
    ff  = {4{32'hFFFFFFFF}};
    pat = {32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'h55555555};
    z   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    wv  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    x7  = 128'h7777_0000_7777_0000_7777_0000_7777_0000;
    y7  = 128'h1212_3434_5656_7878_9A9A_BCBC_DEDE_F0F0;
    pre = 128'h0000_0000_C0DE_0002_0000_0000_C0DE_0002;

    tv[0]  = '{1'b0, 1'b1, 16'h0005, 128'h1,                  4'hF, 128'h0};
    tv[1]  = '{1'b1, 1'b0, 16'h0005, 128'h0,                  4'h0, 128'h1};
    tv[2]  = '{1'b0, 1'b1, 16'h0003, aa,                      4'hF, 128'h1};
    tv[3]  = '{1'b0, 1'b1, 16'h0003, {4{32'h55555555}},       4'h5, 128'h1};
    tv[4]  = '{1'b1, 1'b0, 16'h0003, 128'h0,                  4'h0, pat};
    tv[5]  = '{1'b0, 1'b1, 16'h0003, ff,                      4'h0, pat};
    tv[6]  = '{1'b1, 1'b0, 16'h0003, 128'h0,                  4'h0, pat};
    tv[7]  = '{1'b0, 1'b1, 16'h0002, pre,                     4'hF, pat};
    tv[8]  = '{1'b0, 1'b1, 16'h0401, z,                       4'hF, pat};
    tv[9]  = '{1'b1, 1'b0, 16'h0001, 128'h0,                  4'h0, z};
    tv[10] = '{1'b1, 1'b1, 16'h0001, wv,                      4'hF, z};
    tv[11] = '{1'b1, 1'b0, 16'h0001, 128'h0,                  4'h0, wv};
    tv[12] = '{1'b0, 1'b1, 16'h0007, x7,                      4'hF, wv};

    b0.ren = 0; b0.wen = 0; b0.block_address = 0; b0.din = 0; b0.wmask = 0;
    b1.ren = 0; b1.wen = 0; b1.block_address = 0; b1.din = 0; b1.wmask = 0;

    repeat (2) @(negedge clock);
    chk("rst_ready", 128'(b0.ready), 1);
    chk("rst_done", 128'(b0.done), 0);
    chk("rst_dout", b0.dout, 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      run0(tv[i].r, tv[i].w, tv[i].a, tv[i].d, tv[i].m, tv[i].e, tv[i].w ? 10 : 10);

    // Read of block 2 while address and ren thrash during BUSY.
    @(negedge clock);
    b0.ren = 1'b1; b0.block_address = 16'h0002;
    @(posedge clock);
    #1 b0.ren = 1'b0;
    dones = 0; when = -1;
    for (int k = 0; k < 16; k++) begin
      #2 b0.block_address = 16'($urandom);
      b0.din = {4{$urandom}};
      @(negedge clock);
      if (b0.done) begin
        dones++; when = k;
        chk("stable_dout", b0.dout, pre);
      end
      #2 b0.block_address = 16'($urandom);
      @(posedge clock);
    end
    chk("stable_dones", 128'(dones), 1);
    chk("stable_when", 128'(when), 10);

    // Reset four cycles into a write to block 7.
    @(negedge clock);
    b0.wen = 1'b1; b0.block_address = 16'h0007; b0.din = y7; b0.wmask = 4'hF;
    @(posedge clock);
    #1 b0.wen = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_ready", 128'(b0.ready), 1);
    chk("abort_done", 128'(b0.done), 0);
    chk("abort_dout", b0.dout, 0);
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (b0.done) dones++;
    end
    chk("abort_no_done", 128'(dones), 0);
    run0(1'b1, 1'b0, 16'h0007, 128'h0, 4'h0, x7, 10);

    // Narrow instance: full write/read then masked write/read per address.
    last1 = '0;
    for (int i = 0; i < 16; i++) begin
      a1 = 16'(i * 37);
      d1 = {$urandom, $urandom};
      m1[a1[9:0]] = d1;
      run1(1'b0, 1'b1, a1, d1, 4'hF, last1, 3);
      last1 = m1[a1[9:0]];
      run1(1'b1, 1'b0, a1, 64'h0, 4'h0, last1, 1);
      d1 = {$urandom, $urandom};
      mk = 4'($urandom);
      for (int j = 0; j < 4; j++)
        if (mk[j]) m1[a1[9:0]][j*16 +: 16] = d1[j*16 +: 16];
      run1(1'b0, 1'b1, a1 | 16'hFC00, d1, mk, last1, 3);
      last1 = m1[a1[9:0]];
      run1(1'b1, 1'b0, a1, 64'h0, 4'h0, last1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
